// File: rtl/control_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : control_sequencer_if                                       |
// | Description : Control bus between control_sequencer and DataPath. Holds  |
// |               the instruction/halt inputs, status outputs and the        |
// |               DataPath control strobes.                                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface control_sequencer_if;
  logic [31:0] IR;
  logic        stop;
  logic        run;
  logic        illegal;
  logic [4:0]  alu_op;
  logic        PCout, MARin, IncPC, PCin, Zin, Zlowout;
  logic        ram_read, ram_write, MD_read, MDRin, MDRout, IRin;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, Yin, Cout;

  // Sequencer side: consumes IR/stop, drives status and strobes
  modport master (
    input  IR, stop,
    output run, illegal, alu_op,
    output PCout, MARin, IncPC, PCin, Zin, Zlowout,
    output ram_read, ram_write, MD_read, MDRin, MDRout, IRin,
    output Gra, Grb, Grc, Rin, Rout, BAout, Yin, Cout
  );

  // DataPath side: supplies IR/stop, consumes status and strobes
  modport slave (
    output IR, stop,
    input  run, illegal, alu_op,
    input  PCout, MARin, IncPC, PCin, Zin, Zlowout,
    input  ram_read, ram_write, MD_read, MDRin, MDRout, IRin,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Yin, Cout
  );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : control_sequencer                                          |
// | Description : Hardwired Moore control unit. One control step per clock;  |
// |               strobes decoded from the state register and IR[31:27].     |
// |               Optional macro CTRL_ILLEGAL_TRAP_EN: undefined opcodes set |
// |               the sticky illegal flag and halt (otherwise run as nop).   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module control_sequencer #(
  parameter int             OPW     = 5,
  parameter logic [OPW-1:0] ALU_ADD = 5'b00011
) (
  input  wire logic           clock,
  input  wire logic           clear,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  localparam logic [OPW-1:0] c_OP_LD     = OPW'(0);
  localparam logic [OPW-1:0] c_OP_LDI    = OPW'(1);
  localparam logic [OPW-1:0] c_OP_ST     = OPW'(2);
  localparam logic [OPW-1:0] c_OP_ALU_LO = OPW'(3);
  localparam logic [OPW-1:0] c_OP_ALU_HI = OPW'(6);
  localparam logic [OPW-1:0] c_OP_IMM_LO = OPW'(12);
  localparam logic [OPW-1:0] c_OP_IMM_HI = OPW'(14);
  localparam logic [OPW-1:0] c_OP_HALT   = OPW'(27);

  state_t         r_state;
  logic           r_stop_pend;
  logic [OPW-1:0] w_op;
  logic           w_is_ld, w_is_ldi, w_is_st, w_is_alu, w_is_imm, w_is_halt;
  logic           w_short, w_last, w_halt_req, w_trap;

  assign w_op       = bus.IR[31 -: OPW];
  assign w_is_ld    = (w_op == c_OP_LD);
  assign w_is_ldi   = (w_op == c_OP_LDI);
  assign w_is_st    = (w_op == c_OP_ST);
  assign w_is_alu   = (w_op >= c_OP_ALU_LO) && (w_op <= c_OP_ALU_HI);
  assign w_is_imm   = (w_op >= c_OP_IMM_LO) && (w_op <= c_OP_IMM_HI);
  assign w_is_halt  = (w_op == c_OP_HALT);
  // nop, halt and every undefined opcode finish in T3
  assign w_short    = !(w_is_ld || w_is_ldi || w_is_st || w_is_alu || w_is_imm);
  assign w_last     = ((r_state == T3) && w_short) ||
                      ((r_state == T5) && (w_is_ldi || w_is_alu || w_is_imm)) ||
                      (r_state == T7);
  // a stop seen this cycle counts as well as one remembered earlier
  assign w_halt_req = r_stop_pend || bus.stop;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [OPW-1:0] c_OP_NOP = OPW'(26);
  logic r_illegal;
  assign w_trap      = (r_state == T3) && w_short && (w_op != c_OP_NOP) && !w_is_halt;
  assign bus.illegal = r_illegal;

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clock or posedge clear) begin
    if (clear)       r_illegal <= 1'b0;
    else if (w_trap) r_illegal <= 1'b1;
  end
`else
  assign w_trap      = 1'b0;
  assign bus.illegal = 1'b0;
`endif

  // State sequencing and pending-stop capture; HALT is left only through reset
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state     <= IDLE;
      r_stop_pend <= 1'b0;
    end else begin
      if (bus.stop) r_stop_pend <= 1'b1;
      case (r_state)
        IDLE:   r_state <= w_halt_req ? HALT : T0;
        T0:     r_state <= T1;
        T1:     r_state <= T2;
        T2:     r_state <= T3;
        T3, T4, T5, T6, T7: begin
          if (w_last)
            r_state <= (w_halt_req || w_trap || ((r_state == T3) && w_is_halt)) ? HALT : T0;
          else
            r_state <= state_t'(r_state + 4'd1);
        end
        HALT:   r_state <= HALT;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobe decode from the state register, so execute steps see the IR loaded by T2
  always_comb begin
    bus.run       = (r_state != IDLE) && (r_state != HALT);
    bus.alu_op    = '0;
    bus.PCout     = 1'b0; bus.MARin   = 1'b0; bus.IncPC    = 1'b0; bus.PCin  = 1'b0;
    bus.Zin       = 1'b0; bus.Zlowout = 1'b0; bus.ram_read = 1'b0; bus.ram_write = 1'b0;
    bus.MD_read   = 1'b0; bus.MDRin   = 1'b0; bus.MDRout   = 1'b0; bus.IRin  = 1'b0;
    bus.Gra       = 1'b0; bus.Grb     = 1'b0; bus.Grc      = 1'b0; bus.Rin   = 1'b0;
    bus.Rout      = 1'b0; bus.BAout   = 1'b0; bus.Yin      = 1'b0; bus.Cout  = 1'b0;
    case (r_state)
      T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
      T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.ram_read = 1'b1;
        bus.MD_read = 1'b1; bus.MDRin = 1'b1;
      end
      T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      T3: begin
        if (w_is_ld || w_is_ldi || w_is_st) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
        end else if (w_is_alu || w_is_imm) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end
      end
      T4: begin
        bus.Zin = 1'b1;
        if (w_is_alu) begin
          bus.Grc = 1'b1; bus.Rout = 1'b1; bus.alu_op = w_op;
        end else if (w_is_imm) begin
          bus.Cout = 1'b1; bus.alu_op = w_op;
        end else begin
          bus.Cout = 1'b1; bus.alu_op = ALU_ADD;
        end
      end
      T5: begin
        bus.Zlowout = 1'b1;
        if (w_is_ld || w_is_st) bus.MARin = 1'b1;
        else begin bus.Gra = 1'b1; bus.Rin = 1'b1; end
      end
      T6: begin
        bus.MDRin = 1'b1;
        if (w_is_st) begin bus.Gra = 1'b1; bus.Rout = 1'b1; end
        else begin bus.ram_read = 1'b1; bus.MD_read = 1'b1; end
      end
      T7: begin
        if (w_is_st) bus.ram_write = 1'b1;
        else begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
      end
      default: ;
    endcase
  end

  // Only one source may drive the shared bus in any step
  a_single_bus_driver: assert property (@(posedge clock) disable iff (clear)
    $onehot0({bus.PCout, bus.Zlowout, bus.MDRout, bus.Rout, bus.BAout, bus.Cout}));

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_control_sequencer                                       |
// | Description : Self-checking bench for control_sequencer. An instruction- |
// |               level model predicts the strobe word of every cycle; a     |
// |               set of literal expectations pins the model.                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_control_sequencer;

  logic clock;
  logic clear;
  int   errors = 0;
  int   checks = 0;

  control_sequencer_if bus();

  control_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe bit positions of the packed word {alu_op[4:0], strobes[19:0]}
  localparam logic [24:0] PCOUT = 25'd1 << 0,  MARIN = 25'd1 << 1,  INCPC  = 25'd1 << 2;
  localparam logic [24:0] PCIN  = 25'd1 << 3,  ZIN   = 25'd1 << 4,  ZLOW   = 25'd1 << 5;
  localparam logic [24:0] RRD   = 25'd1 << 6,  RWR   = 25'd1 << 7,  MDRD   = 25'd1 << 8;
  localparam logic [24:0] MDRIN = 25'd1 << 9,  MDROUT= 25'd1 << 10, IRIN   = 25'd1 << 11;
  localparam logic [24:0] GRA   = 25'd1 << 12, GRB   = 25'd1 << 13, GRC    = 25'd1 << 14;
  localparam logic [24:0] RIN   = 25'd1 << 15, ROUT  = 25'd1 << 16, BAOUT  = 25'd1 << 17;
  localparam logic [24:0] YIN   = 25'd1 << 18, COUT  = 25'd1 << 19;
  localparam logic [24:0] A_ADD = 25'd3 << 20;

  function automatic logic [24:0] dut_word();
    return {bus.alu_op, bus.Cout, bus.Yin, bus.BAout, bus.Rout, bus.Rin, bus.Grc,
            bus.Grb, bus.Gra, bus.IRin, bus.MDRout, bus.MDRin, bus.MD_read,
            bus.ram_write, bus.ram_read, bus.Zlowout, bus.Zin, bus.PCin, bus.IncPC,
            bus.MARin, bus.PCout};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode = M_IDLE;
  logic [24:0] m_q[$];
  bit          m_in_fetch = 1'b0;
  bit          m_end_halt = 1'b0;
  bit          m_trap     = 1'b0;
  bit          m_pend     = 1'b0;
  bit          m_ill      = 1'b0;

  function automatic void load_fetch();
    m_q = '{PCOUT | MARIN | INCPC | ZIN,
            ZLOW | PCIN | RRD | MDRD | MDRIN,
            MDROUT | IRIN};
    m_in_fetch = 1'b1;
  endfunction

  function automatic void load_exec(input logic [31:0] ir);
    logic [4:0]  op;
    logic [24:0] a_op;
    op         = ir[31:27];
    a_op       = {op, 20'd0};
    m_in_fetch = 1'b0;
    m_end_halt = 1'b0;
    m_trap     = 1'b0;
    if (op == 5'd0)
      m_q = '{GRB | BAOUT | YIN, A_ADD | COUT | ZIN, ZLOW | MARIN,
              RRD | MDRD | MDRIN, MDROUT | GRA | RIN};
    else if (op == 5'd1)
      m_q = '{GRB | BAOUT | YIN, A_ADD | COUT | ZIN, ZLOW | GRA | RIN};
    else if (op == 5'd2)
      m_q = '{GRB | BAOUT | YIN, A_ADD | COUT | ZIN, ZLOW | MARIN,
              GRA | ROUT | MDRIN, RWR};
    else if (op >= 5'd3 && op <= 5'd6)
      m_q = '{GRB | ROUT | YIN, a_op | GRC | ROUT | ZIN, ZLOW | GRA | RIN};
    else if (op >= 5'd12 && op <= 5'd14)
      m_q = '{GRB | ROUT | YIN, a_op | COUT | ZIN, ZLOW | GRA | RIN};
    else begin
      m_q        = '{25'd0};
      m_end_halt = (op == 5'd27);
`ifdef CTRL_ILLEGAL_TRAP_EN
      m_trap     = (op != 5'd26) && (op != 5'd27);
`endif
    end
  endfunction

  // Model advances on the same edges as the design
  initial begin
    forever begin
      bit req;
      @(posedge clock or posedge clear);
      if (clear) begin
        m_mode = M_IDLE; m_q.delete(); m_pend = 1'b0; m_ill = 1'b0;
      end else begin
        req = m_pend || bus.stop;
        if (bus.stop) m_pend = 1'b1;
        if (m_mode == M_IDLE) begin
          if (req) m_mode = M_HALT;
          else begin m_mode = M_RUN; load_fetch(); end
        end else if (m_mode == M_RUN) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            if (m_in_fetch) load_exec(bus.IR);
            else begin
              if (m_trap) m_ill = 1'b1;
              if (req || m_end_halt || m_trap) m_mode = M_HALT;
              else load_fetch();
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison of {illegal, run, alu_op, strobes} against the model
  initial begin
    forever begin
      logic [24:0] exp_w;
      @(negedge clock);
      exp_w = (m_mode == M_RUN && m_q.size() > 0) ? m_q[0] : 25'd0;
      check("model", {5'd0, bus.illegal, bus.run, dut_word()},
                     {5'd0, m_ill, (m_mode == M_RUN), exp_w});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic run_instr(input logic [31:0] ir, input int n);
    bus.IR = ir;
    for (int k = 0; k < n; k++) step();
    check("instr_back_t0", {7'd0, dut_word()}, 32'h17);
  endtask

  initial begin
    logic rin_seen;
    clear = 1'b1; bus.stop = 1'b0; bus.IR = 32'h02100063;
    step(); step();
    check("reset_strobes", {7'd0, dut_word()}, 32'h0);
    check("reset_run", {31'd0, bus.run}, 32'h0);
    clear = 1'b0;
    step();
    check("first_t0", {7'd0, dut_word()}, 32'h17);
    check("first_run", {31'd0, bus.run}, 32'h1);
    // ld R4,0x63(R2)
    step(); step(); step();
    check("ld_t3", {7'd0, dut_word()}, 32'h62000);
    step(); step(); step();
    check("ld_t6", {7'd0, dut_word()}, 32'h340);
    step();
    check("ld_t7", {7'd0, dut_word()}, 32'h9400);
    step();
    check("ld_back_t0", {7'd0, dut_word()}, 32'h17);
    // add R5,R2,R4 with IR scrambled during fetch
    bus.IR = 32'hFFFFFFFF;
    step(); step();
    bus.IR = 32'h1A920000;
    step(); step();
    check("add_t4", {7'd0, dut_word()}, 32'h314010);
    step();
    check("add_t5", {7'd0, dut_word()}, 32'h9020);
    step();
    check("add_back_t0", {7'd0, dut_word()}, 32'h17);
    // st R6,0x1F
    bus.IR   = 32'h1300001F;
    rin_seen = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      rin_seen = rin_seen | bus.Rin;
      if (k == 6) check("st_t6", {7'd0, dut_word()}, 32'h11200);
      if (k == 7) check("st_t7", {7'd0, dut_word()}, 32'h80);
    end
    check("st_no_rin", {31'd0, rin_seen}, 32'h0);
    step();
    // ld with stop pulsed in T4
    bus.IR = 32'h02100063;
    step(); step(); step(); step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    step(); step();
    check("stop_ld_t7", {7'd0, dut_word()}, 32'h9400);
    step();
    bus.IR = 32'hD8000000;
    for (int k = 0; k < 20; k++) begin
      check("halt_run", {31'd0, bus.run}, 32'h0);
      check("halt_strobes", {7'd0, dut_word()}, 32'h0);
      step();
    end
    // undefined opcode
    clear = 1'b1; bus.IR = 32'hF8000000;
    step(); step();
    clear = 1'b0;
    step(); step(); step(); step();
    check("undef_t3", {6'd0, bus.run, dut_word()}, 32'h2000000);
    step();
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("undef_trap_illegal", {30'd0, bus.illegal, bus.run}, 32'h2);
`else
    check("undef_nop_illegal", {30'd0, bus.illegal, bus.run}, 32'h1);
    check("undef_nop_t0", {7'd0, dut_word()}, 32'h17);
`endif
    // assorted instructions checked by the model
    clear = 1'b1;
    step(); step();
    clear = 1'b0;
    step();
    run_instr(32'hD0000000, 4);   // nop
    run_instr(32'h0A000005, 6);   // ldi
    run_instr(32'h68000007, 6);   // andi
    run_instr(32'h30000000, 6);   // or
    run_instr(32'h20000000, 6);   // sub
    // clear during T5 of ld drops everything at once
    bus.IR = 32'h02100063;
    step(); step(); step(); step(); step();
    clear = 1'b1;
    #1;
    check("clear_t5_strobes", {7'd0, dut_word()}, 32'h0);
    check("clear_t5_run", {31'd0, bus.run}, 32'h0);
    step(); step();
    // stop while idle goes straight to HALT
    clear = 1'b0; bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    step();
    check("idle_stop_halt", {6'd0, bus.run, dut_word()}, 32'h0);
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
